// File: rtl/shared_ram_port_arbiter_pkg.sv
// Shared definitions for the shared-RAM port arbiter: FSM state encoding
// and default bus widths.
package shared_ram_pkg;

    localparam int DEF_NUM_PORTS = 4;
    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_DATA_W    = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/shared_ram_port_arbiter_if.sv
// Bundle of per-port request lines and shared response lines between the
// peripheral initiators (master) and the shared-RAM responder (slave).
interface shared_ram_port_arbiter_if
    import shared_ram_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W
) ();

    localparam int IDX_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]        req;
    logic [NUM_PORTS-1:0]        we;
    logic [NUM_PORTS*ADDR_W-1:0] addr;
    logic [NUM_PORTS*DATA_W-1:0] wdata;
    logic [NUM_PORTS-1:0]        ack;
    logic [DATA_W-1:0]           rdata;
    logic [IDX_W-1:0]            grant_id;
    logic                        busy;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata, grant_id, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata, grant_id, busy
    );

endinterface

// File: rtl/shared_ram_port_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past rr_ptr, so
// the port served last has the lowest priority on the next decision.
module rr_arbiter #(
    parameter int NUM_PORTS = 4,
    localparam int IDX_W = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     winner,
    output logic                 any_req
);

    // Requests rotated so that bit 0 is the highest-priority port.
    logic [NUM_PORTS-1:0] rot_req;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_rot
        assign rot_req[gi] = req[IDX_W'((int'(rr_ptr) + 1 + gi) % NUM_PORTS)];
    end

    assign any_req = |req;

    // Priority-encode the rotated vector and map the offset back to a port.
    always_comb begin
        int   offset;
        logic found;
        offset = 0;
        found  = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!found && rot_req[k]) begin
                offset = k;
                found  = 1'b1;
            end
        end
        winner = IDX_W'((int'(rr_ptr) + 1 + offset) % NUM_PORTS);
        grant  = '0;
        if (any_req) begin
            grant[winner] = 1'b1;
        end
    end

endmodule

// File: rtl/shared_ram_port_arbiter.sv
// Responder for the peripheral-to-shared-RAM protocol: arbitrates the
// request ports round-robin, serializes accesses on one single-port RAM and
// returns a one-cycle ack (plus read data) to the served port.
module shared_ram_port_arbiter
    import shared_ram_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    shared_ram_port_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam int DEPTH = 2 ** ADDR_W;

    state_t state_reg, state_next;

    logic [IDX_W-1:0]  rr_ptr_reg;
    logic [IDX_W-1:0]  grant_id_reg;
    logic              lat_we_reg;
    logic [ADDR_W-1:0] lat_addr_reg;
    logic [DATA_W-1:0] lat_wdata_reg;
    logic [DATA_W-1:0] rdata_reg;

    // Contents are deliberately never reset; they survive rst.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [NUM_PORTS-1:0] arb_grant;
    logic [IDX_W-1:0]     arb_winner;
    logic                 arb_any;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              mem_we;

    rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
        .req     (bus.req),
        .rr_ptr  (rr_ptr_reg),
        .grant   (arb_grant),
        .winner  (arb_winner),
        .any_req (arb_any)
    );

    // One-hot AND-OR mux of the winning port's request fields.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (arb_grant[i]) begin
                sel_we    = bus.we[i];
                sel_addr  = bus.addr[i*ADDR_W +: ADDR_W];
                sel_wdata = bus.wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state logic: IDLE waits for any request, then a fixed
    // ACCESS -> RESP -> IDLE sequence.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (arb_any) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; rst abandons any transaction in flight at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Latch the winner at grant, so later request changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_id_reg  <= '0;
            lat_we_reg    <= 1'b0;
            lat_addr_reg  <= '0;
            lat_wdata_reg <= '0;
        end else if (state_reg == IDLE && arb_any) begin
            grant_id_reg  <= arb_winner;
            lat_we_reg    <= sel_we;
            lat_addr_reg  <= sel_addr;
            lat_wdata_reg <= sel_wdata;
        end
    end

    // Rotation pointer moves to the served port once its ack is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg <= IDX_W'(NUM_PORTS - 1);
        end else if (state_reg == RESP) begin
            rr_ptr_reg <= grant_id_reg;
        end
    end

    // The !rst term keeps a write from landing if rst rises on the edge.
    assign mem_we = (state_reg == ACCESS) && lat_we_reg && !rst;

    // RAM write port.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[lat_addr_reg] <= lat_wdata_reg;
        end
    end

    // Registered read; holds the last read value through writes and idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_reg <= '0;
        end else if (state_reg == ACCESS && !lat_we_reg) begin
            rdata_reg <= mem[lat_addr_reg];
        end
    end

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ack
        assign bus.ack[gi] = (state_reg == RESP) && (grant_id_reg == IDX_W'(gi));
    end

    assign bus.rdata    = rdata_reg;
    assign bus.grant_id = grant_id_reg;
    assign bus.busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_shared_ram_port_arbiter.sv
// Bench for shared_ram_port_arbiter: per-port initiator agents driven from
// transaction queues, a transaction-level reference model checked on every
// cycle, and literal expectations for the directed scenarios.
module tb_shared_ram_port_arbiter;
    import shared_ram_pkg::*;

    localparam int NP = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shared_ram_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus_if ();

    shared_ram_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            gap;
    } txn_t;

    typedef struct {
        int            port;
        logic [DW-1:0] rdata;
        int            cyc;
    } ev_t;

    txn_t pq [NP][$];
    ev_t  log_q [$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int p, input bit w, input int a, input int d, input int g);
        txn_t t;
        t.we    = w;
        t.addr  = AW'(a);
        t.wdata = DW'(d);
        t.gap   = g;
        pq[p].push_back(t);
    endtask

    // ---------------- reference model (transaction level) ----------------
    // A granted transaction lives for three edges: memory effect one edge
    // after grant (ack visible in that cycle), retired on the next edge.
    logic [DW-1:0] m_mem [256];
    bit            m_active = 1'b0;
    int            m_age    = 0;
    int            m_port   = 0;
    int            m_last   = NP - 1;
    int            m_grant  = 0;
    logic          m_we     = 1'b0;
    logic [AW-1:0] m_addr   = '0;
    logic [DW-1:0] m_wdata  = '0;
    logic [DW-1:0] m_rdata  = '0;

    function automatic int pick(input logic [NP-1:0] r, input int last);
        for (int k = 1; k <= NP; k++) begin
            if (r[(last + k) % NP]) return (last + k) % NP;
        end
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_age    = 0;
            m_last   = NP - 1;
            m_rdata  = '0;
            m_grant  = 0;
        end else if (m_active) begin
            m_age++;
            if (m_age == 1) begin
                if (m_we) m_mem[m_addr] = m_wdata;
                else      m_rdata = m_mem[m_addr];
            end else begin
                m_active = 1'b0;
                m_last   = m_port;
            end
        end else if (|bus_if.req) begin
            m_port   = pick(bus_if.req, m_last);
            m_grant  = m_port;
            m_we     = bus_if.we[m_port];
            m_addr   = bus_if.addr[m_port*AW +: AW];
            m_wdata  = bus_if.wdata[m_port*DW +: DW];
            m_active = 1'b1;
            m_age    = 0;
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    int ncyc = 0;
    always @(negedge clk) begin
        logic [NP-1:0] e_ack;
        ev_t           ev;
        if (!rst) begin
            ncyc++;
            e_ack = (m_active && m_age == 1) ? (NP'(1) << m_port) : '0;
            chk("cyc_ack", int'(bus_if.ack), int'(e_ack));
            chk("cyc_busy", int'(bus_if.busy), int'(m_active));
            chk("cyc_grant_id", int'(bus_if.grant_id), m_grant);
            chk("cyc_rdata", int'(bus_if.rdata), int'(m_rdata));
            for (int p = 0; p < NP; p++) begin
                if (bus_if.ack[p]) begin
                    ev.port  = p;
                    ev.rdata = bus_if.rdata;
                    ev.cyc   = ncyc;
                    log_q.push_back(ev);
                end
            end
        end
    end

    // ---------------- initiator agents ----------------
    bit active   [NP];
    bit seen_ack [NP];
    int wait_cnt [NP];

    always @(negedge clk) begin
        txn_t t;
        if (rst) begin
            for (int p = 0; p < NP; p++) begin
                active[p]   = 1'b0;
                seen_ack[p] = 1'b0;
                wait_cnt[p] = 0;
                pq[p].delete();
            end
            bus_if.req   = '0;
            bus_if.we    = '0;
            bus_if.addr  = '0;
            bus_if.wdata = '0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (active[p] && seen_ack[p]) begin
                    active[p]     = 1'b0;
                    seen_ack[p]   = 1'b0;
                    bus_if.req[p] = 1'b0;
                end
                if (!active[p] && pq[p].size() > 0) begin
                    if (wait_cnt[p] < pq[p][0].gap) begin
                        wait_cnt[p]++;
                    end else begin
                        t = pq[p].pop_front();
                        wait_cnt[p]                  = 0;
                        active[p]                    = 1'b1;
                        bus_if.req[p]                = 1'b1;
                        bus_if.we[p]                 = t.we;
                        bus_if.addr[p*AW +: AW]      = t.addr;
                        bus_if.wdata[p*DW +: DW]     = t.wdata;
                    end
                end
                if (active[p] && bus_if.ack[p]) seen_ack[p] = 1'b1;
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        repeat (2) @(negedge clk);
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            done = !bus_if.busy;
            for (int p = 0; p < NP; p++) begin
                if (active[p] || pq[p].size() != 0) done = 1'b0;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wait_idle: not idle after %0d cycles, required idle", budget);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int vals [4] = '{'hAA, 'hBB, 'hCC, 'hDD};

    initial begin
        bit hit;
        bit prev;
        int n;

        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("reset_ack", int'(bus_if.ack), 0);
        chk("reset_busy", int'(bus_if.busy), 0);
        chk("reset_rdata", int'(bus_if.rdata), 0);
        chk("reset_grant_id", int'(bus_if.grant_id), 0);

        // Each port writes then reads back its own location.
        for (int p = 0; p < NP; p++) begin
            log_q.delete();
            push(p, 1'b1, p * 'h10, vals[p], 0);
            push(p, 1'b0, p * 'h10, 0, 0);
            wait_idle(100);
            chk("t1_ack_count", log_q.size(), 2);
            if (log_q.size() == 2) begin
                chk("t1_port", log_q[0].port, p);
                chk("t1_read_port", log_q[1].port, p);
                chk("t1_read_data", int'(log_q[1].rdata), vals[p]);
            end
        end

        // All four ports read at once: served 0,1,2,3, three cycles apart.
        log_q.delete();
        for (int p = 0; p < NP; p++) push(p, 1'b0, p * 'h10, 0, 0);
        wait_idle(200);
        chk("t2_ack_count", log_q.size(), 4);
        if (log_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t2_order", log_q[i].port, i);
                chk("t2_rdata", int'(log_q[i].rdata), vals[i]);
                if (i > 0) chk("t2_spacing", log_q[i].cyc - log_q[i-1].cyc, 3);
            end
        end

        // Port 2 served last, then 1 and 3 together: 3 wins first.
        push(2, 1'b0, 'h20, 0, 0);
        wait_idle(100);
        log_q.delete();
        push(1, 1'b0, 'h10, 0, 0);
        push(3, 1'b0, 'h30, 0, 0);
        wait_idle(100);
        chk("t3_ack_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("t3_first", log_q[0].port, 3);
            chk("t3_second", log_q[1].port, 1);
        end

        // Cross-port read-after-write, then rdata holds through a write.
        log_q.delete();
        push(1, 1'b1, 'h40, 'h5A, 0);
        wait_idle(100);
        push(2, 1'b0, 'h40, 0, 0);
        wait_idle(100);
        push(0, 1'b1, 'h41, 'h33, 0);
        wait_idle(100);
        chk("t4_ack_count", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk("t4_read_data", int'(log_q[1].rdata), 'h5A);
            chk("t4_write_ack_rdata", int'(log_q[2].rdata), 'h5A);
        end
        chk("t4_rdata_hold", int'(bus_if.rdata), 'h5A);

        // Reset during ACCESS of a write: write dropped, no ack.
        push(0, 1'b1, 'h50, 'h11, 0);
        wait_idle(100);
        log_q.delete();
        push(0, 1'b1, 'h50, 'h77, 0);
        hit  = 1'b0;
        prev = 1'b0;
        n    = 0;
        while (!hit && n < 50) begin
            @(negedge clk);
            n++;
            if (bus_if.busy && !prev) hit = 1'b1;
            prev = bus_if.busy;
        end
        chk("t5_found_access", int'(hit), 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_busy_async", int'(bus_if.busy), 0);
        chk("t5_ack_async", int'(bus_if.ack), 0);
        chk("t5_rdata_async", int'(bus_if.rdata), 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        chk("t5_no_ack", log_q.size(), 0);
        push(0, 1'b0, 'h50, 0, 0);
        push(1, 1'b0, 'h50, 0, 0);
        wait_idle(100);
        chk("t5_ack_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("t5_rr_reset_first", log_q[0].port, 0);
            chk("t5_old_data", int'(log_q[0].rdata), 'h11);
            chk("t5_second", log_q[1].port, 1);
        end

        // Port 0 requests back-to-back against port 1: strict alternation.
        log_q.delete();
        for (int i = 0; i < 4; i++) begin
            push(0, 1'b0, 'h00, 0, 0);
            push(1, 1'b0, 'h10, 0, 0);
        end
        wait_idle(200);
        chk("t6_ack_count", log_q.size(), 8);
        if (log_q.size() == 8) begin
            for (int i = 0; i < 8; i++) chk("t6_alternate", log_q[i].port, i % 2);
        end

        // Randomized traffic over a pre-written window.
        for (int a = 0; a < 8; a++) push(0, 1'b1, 'h80 + a, $urandom_range(0, 255), 0);
        wait_idle(200);
        log_q.delete();
        for (int p = 0; p < NP; p++) begin
            for (int i = 0; i < 12; i++) begin
                push(p, 1'($urandom_range(0, 1)), 'h80 + $urandom_range(0, 7),
                     $urandom_range(0, 255), $urandom_range(0, 3));
            end
        end
        wait_idle(3000);
        chk("rand_ack_count", log_q.size(), 48);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
